// File: rtl/fifo_std_to_axis_skid.sv
// Three-entry circular skid store between the FIFO read port and the stream output.
// Pointers wrap explicitly at the last slot; a push and a pop in the same cycle keep the level.
module fifo_std_to_axis_skid #(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic [1:0]            level_o
);

    localparam logic [1:0] LAST_PTR = 2'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]            level_q, level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? 2'd0 : wr_ptr_q + 2'd1;
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? 2'd0 : rd_ptr_q + 2'd1;
        end
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + 2'd1;
            2'b01:   level_d = level_q - 2'd1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            level_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the level gates visibility of every slot.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign level_o     = level_q;

endmodule

// File: rtl/fifo_std_to_axis.sv
// Read-side adapter: standard-mode FIFO (read latency 1) to AXI4-Stream master at 1 beat/clock.
// Reads are issued only from registered occupancy and FIFO flags, never from m_tready.
module fifo_std_to_axis #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 0,
    parameter int BUF_DEPTH  = 3
) (
    input  logic                  wr_clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    input  logic                  fifo_rd_rst_busy,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [1:0]            buf_level
);

    logic                  inflight_q;
    logic                  handshake;
    logic [2:0]            occupancy;
    logic [DATA_WIDTH-1:0] head_data;
    logic [1:0]            level;

    // Every issued read must have a slot waiting for it one cycle later.
    assign occupancy  = {1'b0, level} + {2'b00, inflight_q};
    assign fifo_rd_en = !rst && !fifo_empty && !fifo_rd_rst_busy
                        && (occupancy < 3'(BUF_DEPTH));

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
        end
    end

    // A beat transfers when m_tvalid && m_tready; while m_tvalid is high and
    // m_tready low, m_tdata, m_tvalid and m_tlast hold their values.
    assign m_tvalid  = (level != 2'd0);
    assign handshake = m_tvalid && m_tready;
    assign m_tdata   = m_tvalid ? head_data : '0;
    assign buf_level = level;

    fifo_std_to_axis_skid #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_skid (
        .clk_i       (wr_clk),
        .rst_i       (rst),
        .push_i      (inflight_q),
        .push_data_i (fifo_dout),
        .pop_i       (handshake),
        .head_data_o (head_data),
        .level_o     (level)
    );

    if (PKT_LEN == 0) begin : g_no_tlast
        assign m_tlast = 1'b0;
    end else begin : g_tlast
        localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

        logic [15:0] beat_cnt_q, beat_cnt_d;

        always_comb begin
            beat_cnt_d = beat_cnt_q;
            if (handshake) begin
                beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? 16'd0 : beat_cnt_q + 16'd1;
            end
        end

        always_ff @(posedge wr_clk) begin
            if (rst) begin
                beat_cnt_q <= 16'd0;
            end else begin
                beat_cnt_q <= beat_cnt_d;
            end
        end

        assign m_tlast = m_tvalid && (beat_cnt_q == LAST_BEAT);
    end

endmodule

// File: tb/tb_fifo_std_to_axis.sv
// Bench for fifo_std_to_axis: behavioural standard-mode FIFO model, expected-queue scoreboard,
// directed streaming / backpressure / tlast / reset / rd_rst_busy scenarios plus random ready.
module tb_fifo_std_to_axis;

    localparam int DW  = 32;
    localparam int PKT = 4;

    // clock / reset
    logic          wr_clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_rst_busy = 1'b0;
    logic          m_tready = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic [1:0]    buf_level;

    always #5 wr_clk = ~wr_clk;

    fifo_std_to_axis #(
        .DATA_WIDTH (DW),
        .PKT_LEN    (PKT),
        .BUF_DEPTH  (3)
    ) dut (
        .wr_clk           (wr_clk),
        .rst              (rst),
        .fifo_dout        (fifo_dout),
        .fifo_empty       (fifo_empty),
        .fifo_rd_rst_busy (fifo_rd_rst_busy),
        .fifo_rd_en       (fifo_rd_en),
        .m_tdata          (m_tdata),
        .m_tvalid         (m_tvalid),
        .m_tready         (m_tready),
        .m_tlast          (m_tlast),
        .buf_level        (buf_level)
    );

    // FIFO contents and scoreboard
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   beat_idx = 0;
    int   tlast_seen = 0;
    int   rd_pulses = 0;
    logic s_rd = 1'b0;
    logic s_valid = 1'b0;
    logic s_hs = 1'b0;
    logic inflight_m = 1'b0;
    logic held_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + 32'(i));
            exp_q.push_back(base + 32'(i));
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic push_random(input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    // One clock: sample and score away from the edge, then advance the FIFO model.
    task automatic step();
        #1;
        s_rd    = fifo_rd_en;
        s_valid = m_tvalid;
        s_hs    = m_tvalid && m_tready;
        if (!rst) begin
            if (held_m) check("hold_valid", 32'(m_tvalid), 32'd1);
            if (s_rd) begin
                check("rd_on_empty", 32'(fifo_empty), 32'd0);
                rd_pulses++;
            end
            if (inflight_m) check("capture_at_full", 32'(buf_level == 2'd3), 32'd0);
            if (m_tvalid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    check("data", m_tdata, exp_q[0]);
                    check("tlast", 32'(m_tlast), 32'((beat_idx % PKT) == PKT - 1));
                end
            end
            if (s_hs && exp_q.size() != 0) begin
                if (m_tlast) tlast_seen++;
                void'(exp_q.pop_front());
                beat_idx++;
            end
        end
        held_m = !rst && m_tvalid && !m_tready;
        @(posedge wr_clk);
        #1;
        cyc++;
        if (rst) begin
            fifo_q.delete();
            exp_q.delete();
            fifo_dout  = '0;
            inflight_m = 1'b0;
            beat_idx   = 0;
            held_m     = 1'b0;
        end else begin
            inflight_m = s_rd;
            if (s_rd && fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int first_rd;
        int first_v;
        int last_v;
        int vcount;
        int n;

        // reset state
        rst = 1'b1;
        step();
        step();
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_tdata", m_tdata, 32'd0);
        check("rst_level", 32'(buf_level), 32'd0);
        rst = 1'b0;
        step();

        // streaming 0x00..0x0F with ready high
        m_tready = 1'b1;
        push_words(32'h0, 16);
        first_rd = -1;
        first_v  = -1;
        last_v   = -1;
        vcount   = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (s_rd && first_rd < 0) first_rd = cyc;
            if (s_valid) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                vcount++;
            end
        end
        check("stream_latency", 32'(first_v - first_rd), 32'd2);
        check("stream_beats", 32'(vcount), 32'd16);
        check("stream_no_gap", 32'(last_v - first_v + 1), 32'd16);
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // backpressure: 8 words, ready low
        m_tready  = 1'b0;
        rd_pulses = 0;
        push_words(32'h100, 8);
        repeat (8) step();
        check("bp_rd_pulses", 32'(rd_pulses), 32'd3);
        check("bp_level", 32'(buf_level), 32'd3);
        check("bp_head", m_tdata, 32'h100);
        check("bp_rd_en_off", 32'(fifo_rd_en), 32'd0);
        m_tready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check("bp_drain_cycles", 32'(n), 32'd8);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // tlast on 4-beat packets with irregular ready
        rst = 1'b1;
        step();
        rst = 1'b0;
        tlast_seen = 0;
        push_words(32'h200, 12);
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            m_tready = (n % 5 != 2) && (n % 7 != 4);
            step();
            n++;
        end
        check("tlast_drained", 32'(exp_q.size()), 32'd0);
        check("tlast_count", 32'(tlast_seen), 32'd3);

        // reset mid-stream with level 2 and one read in flight
        m_tready = 1'b0;
        push_words(32'h300, 6);
        repeat (3) step();
        check("pre_rst_level", 32'(buf_level), 32'd2);
        check("pre_rst_inflight", 32'(inflight_m), 32'd1);
        check("pre_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        rst = 1'b1;
        fifo_rd_rst_busy = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
        check("mid_rst_level", 32'(buf_level), 32'd0);
        check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        step();
        step();
        check("busy_rd_en", 32'(fifo_rd_en), 32'd0);
        fifo_rd_rst_busy = 1'b0;
        m_tready = 1'b1;
        push_words(32'h400, 5);
        drain("post_rst_drained", 30);

        // rd_rst_busy with two buffered beats
        m_tready = 1'b0;
        push_words(32'h500, 2);
        repeat (5) step();
        check("busy_pre_level", 32'(buf_level), 32'd2);
        fifo_rd_rst_busy = 1'b1;
        push_words(32'h600, 4);
        rd_pulses = 0;
        repeat (3) step();
        m_tready = 1'b1;
        repeat (4) step();
        check("busy_no_reads", 32'(rd_pulses), 32'd0);
        check("busy_level", 32'(buf_level), 32'd0);
        check("busy_tvalid", 32'(m_tvalid), 32'd0);
        check("busy_remaining", 32'(exp_q.size()), 32'd4);
        fifo_rd_rst_busy = 1'b0;
        drain("busy_drained", 30);

        // 1000 random words with random ready
        push_random(1000);
        n = 0;
        while (exp_q.size() != 0 && n < 6000) begin
            m_tready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
